// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the pipeline memory blocks: word width, zero word and
// the arbiter state encoding.
package mem_port_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive data grants made while fetch is waiting; any fetch grant
// clears the count. at_limit tells the arbiter to let fetch through next.
module mem_arb_starve_cnt #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic data_grant,
    input  logic fetch_grant,
    input  logic if_req,
    output logic at_limit
);

    localparam logic [3:0] LIMIT_CNT = 4'(LIMIT);

    logic [3:0] count;

    // Saturating guard keeps the count meaningful even if LIMIT is never reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (fetch_grant) begin
            count <= 4'd0;
        end else if (data_grant && if_req && count != 4'hF) begin
            count <= count + 4'd1;
        end
    end

    assign at_limit = (count == LIMIT_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the MEM stage.
// Optional fetch anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [WORD_W-1:0] dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic [WORD_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_range
        $error("mem_port_arbiter: STARVE_LIMIT must be within 1..15");
    end

    arb_state_t state;
    logic       grant_data;
    logic       grant_fetch;
    logic       fetch_first;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic at_limit;

    mem_arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk        (clk),
        .rst        (rst),
        .data_grant (grant_data),
        .fetch_grant(grant_fetch),
        .if_req     (if_req),
        .at_limit   (at_limit)
    );

    assign fetch_first = at_limit;
`else
    assign fetch_first = 1'b0;
`endif

    // Data wins a tie unless fetch has been starved for too long.
    always_comb begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        if (state == ST_IDLE) begin
            if (dm_req && !(if_req && fetch_first)) begin
                grant_data = 1'b1;
            end else if (if_req) begin
                grant_fetch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= ZERO_WORD;
            mem_wdata <= ZERO_WORD;
            if_rdata  <= ZERO_WORD;
            dm_rdata  <= ZERO_WORD;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_data) begin
                        state     <= ST_DM_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grant_fetch) begin
                        state     <= ST_IF_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= ZERO_WORD;
                    end
                end
                ST_IF_BUSY: begin
                    if (mem_ready) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_valid <= 1'b1;
                    end
                end
                ST_DM_BUSY: begin
                    if (mem_ready) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        dm_valid <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // A requester may advance in the very cycle its access completes.
    assign stall_mem = dm_req && !(state == ST_DM_BUSY && mem_ready);
    assign stall_if  = (if_req && !(state == ST_IF_BUSY && mem_ready)) || stall_mem;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a transaction-level
// reference model; starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, dm_valid, mem_req, mem_we, mem_ready;
    logic        stall_if, stall_mem, busy;

    // Memory responder: ready after wait_cfg stalled cycles, random noise when idle.
    int          wait_cfg;
    int          wait_cnt;
    logic [31:0] rdata_cfg;
    logic        idle_noise;

    int          n_run;
    int          n_fail;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;

    always #5 clk = ~clk;

    assign mem_rdata = rdata_cfg;
    assign mem_ready = mem_req ? (wait_cnt >= wait_cfg) : idle_noise;

    always @(posedge clk) wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;

    mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_run++;
        if ({mem_req, mem_we, if_valid, dm_valid, busy} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, if_valid, dm_valid, busy});
        end
        n_run++;
        if ({mem_addr, mem_wdata} !== 64'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata});
        end
        n_run++;
        if ({if_rdata, dm_rdata} !== 64'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", {if_rdata, dm_rdata});
        end
        exp_if_rdata = 32'd0;
        exp_dm_rdata = 32'd0;
        if_addr = 32'h0000_0abc;
        if_req  = 1'b1;
        tick();
        tick();
        n_run++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_holds_idle: got %b expected 0", mem_req);
        end
        rst       = 1'b0;
        wait_cfg  = 0;
        rdata_cfg = 32'h0bad_cafe;
        tick();
        n_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0abc) begin
            n_fail++;
            $display("[TB] FAIL first_grant: got req=%b addr=%h expected req=1 addr=00000abc", mem_req, mem_addr);
        end
        tick();
        n_run++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h0bad_cafe) begin
            n_fail++;
            $display("[TB] FAIL first_fetch: got valid=%b data=%h expected valid=1 data=0badcafe", if_valid, if_rdata);
        end
        exp_if_rdata = 32'h0bad_cafe;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch_only();
        if_addr   = 32'h0000_0040;
        rdata_cfg = 32'h2008_0005;
        wait_cfg  = 0;
        if_req    = 1'b1;
        #1;
        n_run++;
        if (stall_if !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL fetch_stall_req: got %b expected 1", stall_if);
        end
        tick();
        n_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_wdata !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL fetch_access: got req=%b addr=%h we=%b wd=%h expected 1 00000040 0 0",
                     mem_req, mem_addr, mem_we, mem_wdata);
        end
        tick();
        n_run++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h2008_0005) begin
            n_fail++;
            $display("[TB] FAIL fetch_valid: got valid=%b data=%h expected 1 20080005", if_valid, if_rdata);
        end
        exp_if_rdata = 32'h2008_0005;
        if_req = 1'b0;
        tick();
        n_run++;
        if (if_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fetch_pulse_width: got valid=%b req=%b expected 0 0", if_valid, mem_req);
        end
    endtask

    task automatic test_simultaneous();
        if_addr   = 32'h0000_0044;
        dm_addr   = 32'h0000_0100;
        dm_wdata  = 32'hdead_beef;
        dm_we     = 1'b1;
        rdata_cfg = 32'h1234_5678;
        wait_cfg  = 0;
        if_req    = 1'b1;
        dm_req    = 1'b1;
        #1;
        n_run++;
        if (stall_if !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sim_stall_if_c0: got %b expected 1", stall_if);
        end
        tick();
        n_run++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hdead_beef) begin
            n_fail++;
            $display("[TB] FAIL sim_write_first: got we=%b addr=%h wd=%h expected 1 00000100 deadbeef",
                     mem_we, mem_addr, mem_wdata);
        end
        #1;
        n_run++;
        if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sim_stalls_c1: got if=%b mem=%b expected 1 0", stall_if, stall_mem);
        end
        tick();
        n_run++;
        if (dm_valid !== 1'b1 || dm_rdata !== exp_dm_rdata || if_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sim_write_done: got dv=%b dr=%h iv=%b expected 1 %h 0",
                     dm_valid, dm_rdata, if_valid, exp_dm_rdata);
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
        #1;
        n_run++;
        if (stall_if !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sim_stall_if_c2: got %b expected 1", stall_if);
        end
        tick();
        n_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0 || mem_wdata !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL sim_fetch_follows: got req=%b addr=%h we=%b wd=%h expected 1 00000044 0 0",
                     mem_req, mem_addr, mem_we, mem_wdata);
        end
        #1;
        n_run++;
        if (stall_if !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sim_stall_if_release: got %b expected 0", stall_if);
        end
        tick();
        n_run++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("[TB] FAIL sim_fetch_done: got valid=%b data=%h expected 1 12345678", if_valid, if_rdata);
        end
        exp_if_rdata = 32'h1234_5678;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_wait_states(input int waits);
        int          stall_cnt;
        int          valid_cnt;
        int          valid_at;
        logic [31:0] addr;
        stall_cnt = 0;
        valid_cnt = 0;
        valid_at  = -1;
        addr      = $urandom;
        dm_addr   = addr;
        dm_we     = 1'b0;
        rdata_cfg = $urandom;
        wait_cfg  = waits;
        dm_req    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (stall_mem === 1'b1) stall_cnt++;
            tick();
            if (mem_req === 1'b1) begin
                n_run++;
                if (mem_addr !== addr) begin
                    n_fail++;
                    $display("[TB] FAIL wait_addr_stable: got %h expected %h", mem_addr, addr);
                end
            end
            if (dm_valid === 1'b1) begin
                valid_cnt++;
                valid_at = c + 1;
                dm_req   = 1'b0;
                n_run++;
                if (dm_rdata !== rdata_cfg) begin
                    n_fail++;
                    $display("[TB] FAIL wait_rdata: got %h expected %h", dm_rdata, rdata_cfg);
                end
                exp_dm_rdata = rdata_cfg;
            end
        end
        n_run++;
        if (stall_cnt !== 1 + waits) begin
            n_fail++;
            $display("[TB] FAIL wait_stall_cycles: got %0d expected %0d", stall_cnt, 1 + waits);
        end
        n_run++;
        if (valid_cnt !== 1 || valid_at !== 2 + waits) begin
            n_fail++;
            $display("[TB] FAIL wait_valid: got count=%0d at=%0d expected 1 at %0d", valid_cnt, valid_at, 2 + waits);
        end
    endtask

    // Model: each access starts in an idle cycle s, is busy for wait+1 cycles and
    // pulses valid at s+2+wait; a tie is served data first, then fetch.
    task automatic test_random_traffic(input int n_txn);
        for (int t = 0; t < n_txn; t++) begin
            int          kind, n_acc, k, s, c;
            logic        acc_d  [2];
            logic        acc_we [2];
            logic [31:0] acc_a  [2];
            logic [31:0] acc_wd [2];
            logic [31:0] acc_rd [2];
            int          acc_w  [2];
            logic        vcyc, exp_req, ready_now, exp_sm, exp_si;
            kind     = $urandom_range(0, 2);
            if_addr  = $urandom;
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_we    = 1'($urandom_range(0, 1));
            n_acc    = 0;
            if (kind != 0) begin
                acc_d[n_acc] = 1'b1;  acc_we[n_acc] = dm_we;
                acc_a[n_acc] = dm_addr; acc_wd[n_acc] = dm_wdata;
                n_acc++;
            end
            if (kind != 1) begin
                acc_d[n_acc] = 1'b0;  acc_we[n_acc] = 1'b0;
                acc_a[n_acc] = if_addr; acc_wd[n_acc] = 32'd0;
                n_acc++;
            end
            for (int i = 0; i < 2; i++) begin
                acc_rd[i] = $urandom;
                acc_w[i]  = $urandom_range(0, 3);
            end
            if_req    = (kind != 1);
            dm_req    = (kind != 0);
            k         = 0;
            s         = 0;
            c         = 0;
            wait_cfg  = acc_w[0];
            rdata_cfg = acc_rd[0];
            while (k < n_acc && c < 60) begin
                vcyc = (c == s + 2 + acc_w[k]);
                n_run++;
                if (if_valid !== (vcyc && !acc_d[k]) || dm_valid !== (vcyc && acc_d[k])) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_valid t%0d c%0d: got iv=%b dv=%b expected iv=%b dv=%b",
                             t, c, if_valid, dm_valid, vcyc && !acc_d[k], vcyc && acc_d[k]);
                end
                if (vcyc) begin
                    if (!acc_d[k]) begin
                        exp_if_rdata = acc_rd[k];
                        if_req = 1'b0;
                    end else begin
                        if (!acc_we[k]) exp_dm_rdata = acc_rd[k];
                        dm_req = 1'b0;
                    end
                    s = c;
                    k++;
                    if (k < n_acc) begin
                        wait_cfg  = acc_w[k];
                        rdata_cfg = acc_rd[k];
                    end
                end
                n_run++;
                if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_rdata t%0d c%0d: got if=%h dm=%h expected if=%h dm=%h",
                             t, c, if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
                end
                exp_req = (k < n_acc) && (c > s) && (c <= s + 1 + acc_w[k]);
                n_run++;
                if (mem_req !== exp_req) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_mem_req t%0d c%0d: got %b expected %b", t, c, mem_req, exp_req);
                end else if (exp_req) begin
                    n_run++;
                    if (mem_addr !== acc_a[k] || mem_we !== acc_we[k] || mem_wdata !== acc_wd[k]) begin
                        n_fail++;
                        $display("[TB] FAIL rnd_mem_bus t%0d c%0d: got %h %b %h expected %h %b %h",
                                 t, c, mem_addr, mem_we, mem_wdata, acc_a[k], acc_we[k], acc_wd[k]);
                    end
                end
                idle_noise = 1'($urandom_range(0, 1));
                #1;
                ready_now = exp_req && (c == s + 1 + acc_w[k]);
                exp_sm    = dm_req && !(ready_now && acc_d[k]);
                exp_si    = (if_req && !(ready_now && !acc_d[k])) || exp_sm;
                n_run++;
                if (stall_mem !== exp_sm || stall_if !== exp_si) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_stall t%0d c%0d: got mem=%b if=%b expected mem=%b if=%b",
                             t, c, stall_mem, stall_if, exp_sm, exp_si);
                end
                if (k < n_acc) begin
                    tick();
                    c++;
                end
            end
            n_run++;
            if (k != n_acc) begin
                n_fail++;
                $display("[TB] FAIL rnd_timeout t%0d: got %0d done expected %0d", t, k, n_acc);
            end
            tick();
            n_run++;
            if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rnd_pulse_width t%0d: got iv=%b dv=%b expected 0 0", t, if_valid, dm_valid);
            end
        end
        idle_noise = 1'b0;
    endtask

    task automatic test_starvation();
        logic exp_fetch [4];
        logic prev_req;
        int   g;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_fetch = '{1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_fetch = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        if_addr   = 32'h0000_0300;
        dm_addr   = 32'h0000_0200;
        dm_we     = 1'b0;
        wait_cfg  = 0;
        rdata_cfg = $urandom;
        if_req    = 1'b1;
        dm_req    = 1'b1;
        prev_req  = mem_req;
        g         = 0;
        for (int c = 0; c < 40 && g < 4; c++) begin
            tick();
            if (mem_req === 1'b1 && prev_req === 1'b0) begin
                n_run++;
                if ((mem_addr == 32'h300) !== exp_fetch[g]) begin
                    n_fail++;
                    $display("[TB] FAIL starve_grant%0d: got fetch=%b expected fetch=%b", g, mem_addr == 32'h300, exp_fetch[g]);
                end
                g++;
            end
            prev_req = mem_req;
        end
        n_run++;
        if (g != 4) begin
            n_fail++;
            $display("[TB] FAIL starve_timeout: got %0d grants expected 4", g);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        dm_addr  = 32'h0000_0500;
        dm_we    = 1'b0;
        wait_cfg = 10;
        dm_req   = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_run++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || stall_mem !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_async: got req=%b busy=%b stall=%b expected 0 0 1", mem_req, busy, stall_mem);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_run++;
            if (dm_valid !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rst_mid_no_valid: got dv=%b req=%b expected 0 0", dm_valid, mem_req);
            end
        end
        rst       = 1'b0;
        wait_cfg  = 0;
        rd        = $urandom;
        rdata_cfg = rd;
        tick();
        n_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_regrant: got req=%b addr=%h expected 1 00000500", mem_req, mem_addr);
        end
        tick();
        n_run++;
        if (dm_valid !== 1'b1 || dm_rdata !== rd || if_rdata !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_complete: got dv=%b dr=%h ir=%h expected 1 %h 0", dm_valid, dm_rdata, if_rdata, rd);
        end
        dm_req = 1'b0;
        tick();
    endtask

    initial begin
        n_run      = 0;
        n_fail     = 0;
        if_req     = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        if_addr    = 32'd0;
        dm_addr    = 32'd0;
        dm_wdata   = 32'd0;
        wait_cfg   = 0;
        rdata_cfg  = 32'd0;
        idle_noise = 1'b1;
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_wait_states(4);
        test_random_traffic(40);
        test_starvation();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
